// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes and datapath select codes.
package multi_cycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2, S_LUI, S_ILLEGAL
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_LW_SW = 3'b010;
  localparam logic [2:0] F3_JALR  = 3'b000;
  localparam logic [2:0] F3_BEQ   = 3'b000;
  localparam logic [2:0] F3_BNE   = 3'b001;
  localparam logic [2:0] F3_BLT   = 3'b100;
  localparam logic [2:0] F3_BGE   = 3'b101;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011,
    ALU_XOR = 3'b100, ALU_SLT = 3'b101, ALU_SLTU = 3'b110
  } aluop_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } immsrc_e;

  typedef enum logic [1:0] {SRCA_PC, SRCA_OLDPC, SRCA_REG, SRCA_ZERO} srca_e;
  typedef enum logic [1:0] {SRCB_REG, SRCB_IMM, SRCB_FOUR, SRCB_ZERO} srcb_e;
  typedef enum logic [1:0] {RES_ALUOUT, RES_ALU, RES_MDR, RES_IMM} ressrc_e;
  typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_R, CLS_I} alu_class_e;

endpackage

// File: rtl/multi_cycle_controller_alu_decoder.sv
// ALU operation decoder: maps instruction class, func3 and func7[5] to an aluop plus a legality flag.
module multi_cycle_controller_alu_decoder
  import multi_cycle_controller_pkg::*;
(
  input  alu_class_e cls_i,
  input  logic [2:0] func3_i,
  input  logic       func7b5_i,
  output aluop_e     aluop_o,
  output logic       legal_o
);

  always_comb begin
    aluop_o = ALU_ADD;
    legal_o = 1'b1;
    case (cls_i)
      CLS_SUB: aluop_o = ALU_SUB;
      CLS_R, CLS_I: begin
        case (func3_i)
          3'b000:  aluop_o = (cls_i == CLS_R && func7b5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  aluop_o = ALU_AND;
          3'b110:  aluop_o = ALU_OR;
          3'b100:  aluop_o = ALU_XOR;
          3'b010:  aluop_o = ALU_SLT;
          3'b011:  aluop_o = ALU_SLTU;
          default: legal_o = 1'b0;
        endcase
      end
      default: aluop_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I datapath; Moore outputs except the branch PC load.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zer,
  input  logic       neg,
  output logic       pcen,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluop,
  output logic [1:0] resultsrc,
  output logic [2:0] immsrc,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic       illegal_q;
  alu_class_e cls;
  aluop_e     dec_aluop;
  logic       dec_legal;
  logic       decode_ok;
  state_e     decode_nxt;
  logic       pcen_c, adrsrc_c, memwrite_c, irwrite_c, regwrite_c;
  srca_e      srca_c;
  srcb_e      srcb_c;
  aluop_e     aluop_c;
  ressrc_e    res_c;
  immsrc_e    imm_c;
  logic       unused_func7;

  assign unused_func7 = ^{func7[6], func7[4:0]};

  // Class is kept in its own process so the legality feedback into state_d stays acyclic.
  always_comb begin
    cls = CLS_ADD;
    case (state_q)
      S_DECODE, S_EXECR, S_EXECI: cls = (opcode == OP_R) ? CLS_R : CLS_I;
      S_BRANCH:                   cls = CLS_SUB;
      default:                    cls = CLS_ADD;
    endcase
  end

  multi_cycle_controller_alu_decoder u_alu_dec (
    .cls_i     (cls),
    .func3_i   (func3),
    .func7b5_i (func7[5]),
    .aluop_o   (dec_aluop),
    .legal_o   (dec_legal)
  );

  always_comb begin
    decode_ok  = 1'b1;
    decode_nxt = S_FETCH;
    case (opcode)
      OP_LOAD, OP_STORE: begin decode_ok = (func3 == F3_LW_SW); decode_nxt = S_MEMADR; end
      OP_R:      begin decode_ok = dec_legal; decode_nxt = S_EXECR; end
      OP_I:      begin decode_ok = dec_legal; decode_nxt = S_EXECI; end
      OP_BRANCH: begin
        decode_ok  = func3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE};
        decode_nxt = S_BRANCH;
      end
      OP_JAL:    decode_nxt = S_JAL;
      OP_JALR:   begin decode_ok = (func3 == F3_JALR); decode_nxt = S_JALR; end
      OP_LUI:    decode_nxt = S_LUI;
      default:   decode_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pcen_c     = 1'b0;
    adrsrc_c   = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    srca_c     = SRCA_PC;
    srcb_c     = SRCB_REG;
    aluop_c    = ALU_ADD;
    res_c      = RES_ALUOUT;
    imm_c      = IMM_I;
    case (state_q)
      S_FETCH: begin
        irwrite_c = 1'b1;
        pcen_c    = 1'b1;
        srcb_c    = SRCB_FOUR;
        res_c     = RES_ALU;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        srca_c  = SRCA_OLDPC;
        srcb_c  = SRCB_IMM;
        imm_c   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        if (decode_ok)          state_d = decode_nxt;
        else if (STRICT_DECODE) state_d = S_ILLEGAL;
        else                    state_d = S_FETCH;
      end
      S_MEMADR: begin
        srca_c  = SRCA_REG;
        srcb_c  = SRCB_IMM;
        imm_c   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD:  begin adrsrc_c = 1'b1; state_d = S_MEMWB; end
      S_MEMWB:    begin res_c = RES_MDR; regwrite_c = 1'b1; state_d = S_FETCH; end
      S_MEMWRITE: begin adrsrc_c = 1'b1; memwrite_c = 1'b1; state_d = S_FETCH; end
      S_EXECR: begin
        srca_c  = SRCA_REG;
        aluop_c = dec_aluop;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        srca_c  = SRCA_REG;
        srcb_c  = SRCB_IMM;
        aluop_c = dec_aluop;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin regwrite_c = 1'b1; state_d = S_FETCH; end
      S_BRANCH: begin
        srca_c  = SRCA_REG;
        aluop_c = dec_aluop;
        case (func3)
          F3_BEQ:  pcen_c = zer;
          F3_BNE:  pcen_c = ~zer;
          F3_BLT:  pcen_c = neg;
          F3_BGE:  pcen_c = ~neg;
          default: pcen_c = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      S_JAL, S_JALR2: begin
        pcen_c  = 1'b1;
        srca_c  = SRCA_OLDPC;
        srcb_c  = SRCB_FOUR;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        srca_c  = SRCA_REG;
        srcb_c  = SRCB_IMM;
        state_d = S_JALR2;
      end
      S_LUI: begin
        imm_c      = IMM_U;
        res_c      = RES_IMM;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  assign pcen      = pcen_c & ~rst;
  assign memwrite  = memwrite_c & ~rst;
  assign irwrite   = irwrite_c & ~rst;
  assign regwrite  = regwrite_c & ~rst;
  assign adrsrc    = adrsrc_c;
  assign alusrca   = srca_c;
  assign alusrcb   = srcb_c;
  assign aluop     = aluop_c;
  assign resultsrc = res_c;
  assign immsrc    = imm_c;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench: per-cycle expected control vectors are queued per instruction and compared each cycle.
module tb_multi_cycle_controller;

  localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011;
  localparam logic [6:0] T_I = 7'b0010011, T_BR = 7'b1100011, T_JAL = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111, T_LUI = 7'b0110111;

  typedef struct {
    string       tag;
    logic [17:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic zer = 1'b0, neg = 1'b0;

  logic pcen1, adrsrc1, memwrite1, irwrite1, regwrite1, illegal1;
  logic [1:0] alusrca1, alusrcb1, resultsrc1;
  logic [2:0] aluop1, immsrc1;
  logic pcen2, adrsrc2, memwrite2, irwrite2, regwrite2, illegal2;
  logic [1:0] alusrca2, alusrcb2, resultsrc2;
  logic [2:0] aluop2, immsrc2;
  logic [17:0] out1, out2;

  exp_t q1[$];
  exp_t q2[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multi_cycle_controller #(.STRICT_DECODE(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .zer(zer), .neg(neg),
    .pcen(pcen1), .adrsrc(adrsrc1), .memwrite(memwrite1), .irwrite(irwrite1), .regwrite(regwrite1),
    .alusrca(alusrca1), .alusrcb(alusrcb1), .aluop(aluop1), .resultsrc(resultsrc1),
    .immsrc(immsrc1), .illegal(illegal1)
  );

  multi_cycle_controller #(.STRICT_DECODE(1'b0)) dut_nop (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .zer(zer), .neg(neg),
    .pcen(pcen2), .adrsrc(adrsrc2), .memwrite(memwrite2), .irwrite(irwrite2), .regwrite(regwrite2),
    .alusrca(alusrca2), .alusrcb(alusrcb2), .aluop(aluop2), .resultsrc(resultsrc2),
    .immsrc(immsrc2), .illegal(illegal2)
  );

  assign out1 = {pcen1, adrsrc1, memwrite1, irwrite1, regwrite1, alusrca1, alusrcb1,
                 aluop1, resultsrc1, immsrc1, illegal1};
  assign out2 = {pcen2, adrsrc2, memwrite2, irwrite2, regwrite2, alusrca2, alusrcb2,
                 aluop2, resultsrc2, immsrc2, illegal2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {pcen adrsrc memwrite irwrite regwrite alusrca alusrcb aluop resultsrc immsrc illegal}
  function automatic logic [17:0] v(logic pc, logic adr, logic mw, logic ir, logic rw,
                                    logic [1:0] a, logic [1:0] b, logic [2:0] op,
                                    logic [1:0] res, logic [2:0] imm, logic ill);
    return {pc, adr, mw, ir, rw, a, b, op, res, imm, ill};
  endfunction

  function automatic logic [17:0] v_fetch();
    return v(1, 0, 0, 1, 0, 2'b00, 2'b10, 3'b000, 2'b01, 3'b000, 0);
  endfunction

  function automatic logic [17:0] v_illegal();
    return v(0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1);
  endfunction

  task automatic push1(input string tag, input logic [17:0] e);
    exp_t x;
    x.tag = tag; x.v = e;
    q1.push_back(x);
  endtask

  task automatic push2(input string tag, input logic [17:0] e);
    exp_t x;
    x.tag = {tag, "/nop"}; x.v = e;
    q2.push_back(x);
  endtask

  task automatic push_both(input string tag, input logic [17:0] e);
    push1(tag, e);
    push2(tag, e);
  endtask

  task automatic expect_instr(input string nm, input logic [6:0] op, input logic [2:0] exp_op,
                              input logic exp_pc);
    push_both({nm, ".FETCH"}, v_fetch());
    push_both({nm, ".DECODE"}, v(0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 2'b00,
                                 (op == T_JAL) ? 3'b011 : 3'b010, 0));
    case (op)
      T_LOAD: begin
        push_both({nm, ".MEMADR"}, v(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000, 0));
        push_both({nm, ".MEMREAD"}, v(0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0));
        push_both({nm, ".MEMWB"}, v(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b10, 3'b000, 0));
      end
      T_STORE: begin
        push_both({nm, ".MEMADR"}, v(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b001, 0));
        push_both({nm, ".MEMWRITE"}, v(0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0));
      end
      T_R: begin
        push_both({nm, ".EXECR"}, v(0, 0, 0, 0, 0, 2'b10, 2'b00, exp_op, 2'b00, 3'b000, 0));
        push_both({nm, ".ALUWB"}, v(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0));
      end
      T_I: begin
        push_both({nm, ".EXECI"}, v(0, 0, 0, 0, 0, 2'b10, 2'b01, exp_op, 2'b00, 3'b000, 0));
        push_both({nm, ".ALUWB"}, v(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0));
      end
      T_BR:
        push_both({nm, ".BRANCH"}, v(exp_pc, 0, 0, 0, 0, 2'b10, 2'b00, 3'b001, 2'b00, 3'b000, 0));
      T_JAL: begin
        push_both({nm, ".JAL"}, v(1, 0, 0, 0, 0, 2'b01, 2'b10, 3'b000, 2'b00, 3'b000, 0));
        push_both({nm, ".ALUWB"}, v(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0));
      end
      T_JALR: begin
        push_both({nm, ".JALR"}, v(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000, 0));
        push_both({nm, ".JALR2"}, v(1, 0, 0, 0, 0, 2'b01, 2'b10, 3'b000, 2'b00, 3'b000, 0));
        push_both({nm, ".ALUWB"}, v(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0));
      end
      T_LUI:
        push_both({nm, ".LUI"}, v(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b11, 3'b100, 0));
      default: ;
    endcase
  endtask

  // Entered at posedge+1; each queued entry is one DUT cycle, sampled on the falling edge.
  task automatic run_q();
    exp_t e;
    while (q1.size() > 0) begin
      @(negedge clk);
      e = q1.pop_front();
      check(e.tag, {14'd0, out1}, {14'd0, e.v});
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check(e.tag, {14'd0, out2}, {14'd0, e.v});
      end
      @(posedge clk);
      #1;
    end
    q2.delete();
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input logic n);
    opcode = op; func3 = f3; func7 = f7; zer = z; neg = n;
  endtask

  task automatic exec(input string nm, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic z, input logic n,
                      input logic [2:0] exp_op, input logic exp_pc);
    drive(op, f3, f7, z, n);
    expect_instr(nm, op, exp_op, exp_pc);
    run_q();
  endtask

  task automatic exec_illegal(input string nm, input logic [6:0] op, input logic [2:0] f3);
    drive(op, f3, 7'h00, 1'b0, 1'b0);
    push_both({nm, ".FETCH"}, v_fetch());
    push_both({nm, ".DECODE"}, v(0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 2'b00, 3'b010, 0));
    push2({nm, ".back"}, v_fetch());
    for (int unsigned i = 0; i < 4; i++) push1({nm, ".ILLEGAL"}, v_illegal());
    run_q();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst.en", {28'd0, pcen1, memwrite1, irwrite1, regwrite1}, 32'd0);
      check("rst.en/nop", {28'd0, pcen2, memwrite2, irwrite2, regwrite2}, 32'd0);
      check("rst.illegal", {31'd0, illegal1}, 32'd0);
    end
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    exec("add",   T_R, 3'b000, 7'h00, 0, 0, 3'b000, 0);
    exec("sub",   T_R, 3'b000, 7'h20, 0, 0, 3'b001, 0);
    exec("xor",   T_R, 3'b100, 7'h00, 0, 0, 3'b100, 0);
    exec("or",    T_R, 3'b110, 7'h00, 0, 0, 3'b011, 0);
    exec("slt",   T_R, 3'b010, 7'h00, 0, 0, 3'b101, 0);
    exec("sltu",  T_R, 3'b011, 7'h00, 0, 0, 3'b110, 0);
    exec("addi",  T_I, 3'b000, 7'h20, 0, 0, 3'b000, 0);
    exec("xori",  T_I, 3'b100, 7'h00, 0, 0, 3'b100, 0);
    exec("ori",   T_I, 3'b110, 7'h00, 0, 0, 3'b011, 0);
    exec("slti",  T_I, 3'b010, 7'h00, 0, 0, 3'b101, 0);
    exec("sltiu", T_I, 3'b011, 7'h00, 0, 0, 3'b110, 0);
    exec("lw",    T_LOAD,  3'b010, 7'h00, 0, 0, 3'b000, 0);
    exec("sw",    T_STORE, 3'b010, 7'h00, 0, 0, 3'b000, 0);
    exec("beq_z1", T_BR, 3'b000, 7'h00, 1, 0, 3'b001, 1);
    exec("beq_z0", T_BR, 3'b000, 7'h00, 0, 0, 3'b001, 0);
    exec("bne_z0", T_BR, 3'b001, 7'h00, 0, 1, 3'b001, 1);
    exec("bne_z1", T_BR, 3'b001, 7'h00, 1, 0, 3'b001, 0);
    exec("blt_n1", T_BR, 3'b100, 7'h00, 0, 1, 3'b001, 1);
    exec("blt_n0", T_BR, 3'b100, 7'h00, 1, 0, 3'b001, 0);
    exec("bge_n1", T_BR, 3'b101, 7'h00, 0, 1, 3'b001, 0);
    exec("bge_n0", T_BR, 3'b101, 7'h00, 0, 0, 3'b001, 1);
    exec("jal",   T_JAL,  3'b000, 7'h00, 0, 0, 3'b000, 0);
    exec("jalr",  T_JALR, 3'b000, 7'h00, 0, 0, 3'b000, 0);
    exec("lui",   T_LUI,  3'b101, 7'h00, 0, 0, 3'b000, 0);

    // lw abandoned after MEMADR; the next instruction must start cleanly from FETCH
    drive(T_LOAD, 3'b010, 7'h00, 0, 0);
    push_both("lw_abort.FETCH", v_fetch());
    push_both("lw_abort.DECODE", v(0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 2'b00, 3'b010, 0));
    push_both("lw_abort.MEMADR", v(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000, 0));
    run_q();
    do_reset();
    exec("add2", T_R, 3'b000, 7'h00, 0, 0, 3'b000, 0);

    exec_illegal("op7f", 7'b1111111, 3'b000);
    do_reset();
    exec_illegal("r_f3_001", T_R, 3'b001);
    do_reset();
    exec_illegal("lw_f3_000", T_LOAD, 3'b000);
    do_reset();
    exec_illegal("jalr_f3_001", T_JALR, 3'b001);
    do_reset();
    exec("lui2", T_LUI, 3'b000, 7'h00, 0, 0, 3'b000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
